// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared response codes and write-channel FSM state type
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        GOT_ADDR,
        GOT_DATA,
        RESP
    } wr_state_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - byte-strobed register storage with combinational readback
module axi_lite_regfile #(
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 16,
    localparam int IDX_W    = $clog2(NUM_REGS),
    localparam int STRB_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Clear everything on reset; otherwise merge only the strobed byte lanes
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = regs[rd_idx];

endmodule

// File: rtl/axi_lite_write_slave.sv
// rtl/axi_lite_write_slave.sv - AXI4-Lite write-only slave in front of a byte-strobed register file
module axi_lite_write_slave
    import axi_lite_pkg::*;
#(
    parameter  int ADDR_W   = 32,
    parameter  int DATA_W   = 32,
    parameter  int NUM_REGS = 16,
    localparam int IDX_W    = $clog2(NUM_REGS),
    localparam int STRB_W   = DATA_W / 8
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [2:0]        AWPROT,
    input  logic              WVALID,
    output logic              WREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [STRB_W-1:0] WSTRB,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [1:0]        BRESP,
    input  logic [IDX_W-1:0]  DBG_IDX,
    output logic [DATA_W-1:0] DBG_DATA
);

    wr_state_t         state_q, state_d;
    logic              ready_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        prot_q;
    logic [DATA_W-1:0] data_q;
    logic [STRB_W-1:0] strb_q;
    logic [1:0]        bresp_q;

    logic              aw_hs, w_hs, enter_resp, addr_ok;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;

    // AWPROT is captured alongside the address but nothing decodes it yet
    logic unused_prot;
    assign unused_prot = ^prot_q;

    // Next state, READY/VALID decode and selection of the write beat (live input or latched copy)
    always_comb begin
        state_d    = state_q;
        AWREADY    = 1'b0;
        WREADY     = 1'b0;
        BVALID     = 1'b0;
        enter_resp = 1'b0;
        wr_addr    = addr_q;
        wr_data    = data_q;
        wr_strb    = strb_q;
        unique case (state_q)
            IDLE: begin
                AWREADY = ready_en_q;
                WREADY  = ready_en_q;
                wr_addr = AWADDR;
                wr_data = WDATA;
                wr_strb = WSTRB;
            end
            GOT_ADDR: begin
                WREADY  = 1'b1;
                wr_data = WDATA;
                wr_strb = WSTRB;
            end
            GOT_DATA: begin
                AWREADY = 1'b1;
                wr_addr = AWADDR;
            end
            RESP: begin
                BVALID = 1'b1;
            end
            default: ;
        endcase
        aw_hs = AWVALID && AWREADY;
        w_hs  = WVALID && WREADY;
        unique case (state_q)
            IDLE: begin
                if (aw_hs && w_hs) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else if (aw_hs) begin
                    state_d = GOT_ADDR;
                end else if (w_hs) begin
                    state_d = GOT_DATA;
                end
            end
            GOT_ADDR: begin
                if (w_hs) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            GOT_DATA: begin
                if (aw_hs) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (BREADY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Word-aligned and inside the register window; everything else is SLVERR
    assign addr_ok = (wr_addr[1:0] == 2'b00) && ((wr_addr >> (IDX_W + 2)) == '0);

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Holds READYs low while in reset and for the edge reset is released on
    always_ff @(posedge ACLK) begin
        ready_en_q <= !ARESET;
    end

    // Latch whichever channel arrives first and the response for the completed write
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            addr_q  <= '0;
            prot_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                addr_q <= AWADDR;
                prot_q <= AWPROT;
            end
            if (w_hs) begin
                data_q <= WDATA;
                strb_q <= WSTRB;
            end
            if (enter_resp) begin
                bresp_q <= addr_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign BRESP = bresp_q;

    axi_lite_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk     (ACLK),
        .reset   (ARESET),
        .we      (enter_resp && addr_ok),
        .wr_idx  (wr_addr[IDX_W+1:2]),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_idx  (DBG_IDX),
        .rd_data (DBG_DATA)
    );

endmodule

// File: tb/tb_axi_lite_write_slave.sv
// tb/tb_axi_lite_write_slave.sv - directed bench with a transaction-level model of the write slave
module tb_axi_lite_write_slave;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] AWADDR = '0;
    logic [2:0]  AWPROT = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [1:0]  BRESP;
    logic [3:0]  DBG_IDX = '0;
    logic [31:0] DBG_DATA;

    int total = 0;
    int bad   = 0;
    bit dbg_hold = 1'b0;

    always #5 ACLK = ~ACLK;

    axi_lite_write_slave #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .AWADDR   (AWADDR),
        .AWPROT   (AWPROT),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .BRESP    (BRESP),
        .DBG_IDX  (DBG_IDX),
        .DBG_DATA (DBG_DATA)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: pending address/data beats, an outstanding response, and the register contents
    logic [31:0] m_regs [16];
    bit          m_live = 1'b0, m_was_live = 1'b0;
    bit          m_have_a = 1'b0, m_have_w = 1'b0, m_busy = 1'b0;
    logic [31:0] m_addr = '0, m_data = '0;
    logic [3:0]  m_strb = '0;
    logic [1:0]  m_resp = '0;

    // Model advances on each rising edge from the bench-driven inputs
    always @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < 16; i++) m_regs[i] = '0;
            m_live = 0; m_have_a = 0; m_have_w = 0; m_busy = 0; m_resp = 2'b00;
        end else begin
            m_was_live = m_live;
            m_live = 1;
            if (m_busy) begin
                if (BREADY) m_busy = 0;
            end else if (m_was_live) begin
                if (AWVALID && !m_have_a) begin m_addr = AWADDR; m_have_a = 1; end
                if (WVALID && !m_have_w) begin m_data = WDATA; m_strb = WSTRB; m_have_w = 1; end
                if (m_have_a && m_have_w) begin
                    m_have_a = 0; m_have_w = 0; m_busy = 1;
                    if (m_addr < 32'(NUM_REGS * 4) && m_addr[1:0] == 2'b00) begin
                        m_resp = 2'b00;
                        for (int b = 0; b < 4; b++)
                            if (m_strb[b]) m_regs[m_addr[5:2]][8*b +: 8] = m_data[8*b +: 8];
                    end else begin
                        m_resp = 2'b10;
                    end
                end
            end
        end
    end

    // Compare every cycle on the falling edge and sweep the readback index
    always @(negedge ACLK) begin
        chk("awready", AWREADY, m_live && !m_busy && !m_have_a);
        chk("wready", WREADY, m_live && !m_busy && !m_have_w);
        chk("bvalid", BVALID, m_busy);
        if (m_busy) chk("bresp", BRESP, m_resp);
        chk("dbg_data", DBG_DATA, m_regs[DBG_IDX]);
        if (!dbg_hold) DBG_IDX = DBG_IDX + 4'd1;
    end

    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int aw_dly, input int w_dly, input int b_hold, input logic [1:0] exp_resp);
        int cyc = 0, bw = 0, hs_cyc = -100, bv_cyc = -1;
        bit aw_done = 0, w_done = 0, b_done = 0;
        @(negedge ACLK);
        BREADY = (b_hold == 0);
        while (!b_done && cyc < 60) begin
            AWADDR = a; AWPROT = 3'b010; WDATA = d; WSTRB = s;
            AWVALID = !aw_done && cyc >= aw_dly;
            WVALID  = !w_done && cyc >= w_dly;
            if (BVALID) begin
                if (bv_cyc < 0) bv_cyc = cyc;
                if (bw < b_hold) begin
                    chk("hold_awready", AWREADY, 0);
                    chk("hold_wready", WREADY, 0);
                    chk("hold_bresp", BRESP, exp_resp);
                end
                BREADY = (bw >= b_hold);
                bw++;
                if (BREADY) chk("resp_code", BRESP, exp_resp);
                b_done = BREADY;
            end
            if (AWVALID && AWREADY) begin aw_done = 1; hs_cyc = cyc; end
            if (WVALID && WREADY) begin w_done = 1; hs_cyc = cyc; end
            @(negedge ACLK);
            cyc++;
        end
        AWVALID = 0; WVALID = 0; BREADY = 0;
        chk("xfer_done", b_done, 1);
        chk("b_latency", 64'(bv_cyc - hs_cyc), 64'd1);
    endtask

    task automatic peek(input int idx, input logic [31:0] exp);
        dbg_hold = 1;
        @(posedge ACLK);
        #2;
        DBG_IDX = 4'(idx);
        #1;
        chk("reg_value", DBG_DATA, exp);
        chk("model_value", m_regs[idx], exp);
        dbg_hold = 0;
    endtask

    initial begin
        repeat (3) @(negedge ACLK);
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_bresp", BRESP, 0);
        ARESET = 0;
        @(negedge ACLK);
        chk("ready_rise_aw", AWREADY, 1);
        chk("ready_rise_w", WREADY, 1);

        xfer(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00);
        peek(1, 32'hDEADBEEF);
        xfer(32'h08, 32'h12345678, 4'hF, 0, 3, 0, 2'b00);
        peek(2, 32'h12345678);
        xfer(32'h0C, 32'hAABBCCDD, 4'h5, 2, 0, 0, 2'b00);
        peek(3, 32'h00BB00DD);
        xfer(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 2'b10);
        peek(0, 32'h0);
        xfer(32'h06, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 2'b10);
        peek(1, 32'hDEADBEEF);
        xfer(32'h14, 32'h11111111, 4'h0, 0, 0, 0, 2'b00);
        peek(5, 32'h0);
        xfer(32'h10, 32'hCAFEF00D, 4'hF, 1, 1, 4, 2'b00);
        peek(4, 32'hCAFEF00D);
        xfer(32'h20, 32'h01020304, 4'hF, 0, 0, 0, 2'b00);
        xfer(32'h24, 32'h0A0B0C0D, 4'hC, 0, 0, 0, 2'b00);
        peek(8, 32'h01020304);
        peek(9, 32'h0A0B0000);

        @(negedge ACLK);
        AWADDR = 32'h18; AWVALID = 1;
        chk("pre_rst_awready", AWREADY, 1);
        @(negedge ACLK);
        AWVALID = 0;
        chk("got_addr_awready", AWREADY, 0);
        chk("got_addr_wready", WREADY, 1);
        ARESET = 1;
        @(negedge ACLK);
        chk("mid_rst_awready", AWREADY, 0);
        chk("mid_rst_wready", WREADY, 0);
        chk("mid_rst_bvalid", BVALID, 0);
        chk("mid_rst_bresp", BRESP, 0);
        ARESET = 0;
        peek(1, 32'h0);
        peek(6, 32'h0);
        xfer(32'h18, 32'h5A5A5A5A, 4'hF, 0, 0, 0, 2'b00);
        peek(6, 32'h5A5A5A5A);

        repeat (2) @(negedge ACLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
